// File: rtl/alu_pkg.sv
// Shared widths and ALU control encodings for the issue stage and ALU.
package alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/operand_forward_mux.sv
// Per-operand bypass select: x0, then EX/MEM (non-load), then WB, then register file.
module operand_forward_mux
  import alu_pkg::*;
(
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [RA_W-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_data,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] fwd_data_c
);

  // Priority select; a load in EX has no data yet, so it never forwards.
  always_comb begin
    fwd_data_c = rf_data;
    if (rs_addr == '0) begin
      fwd_data_c = '0;
    end else if (ex_valid && !ex_is_load && (ex_addr == rs_addr)) begin
      fwd_data_c = ex_data;
    end else if (wb_valid && (wb_addr == rs_addr)) begin
      fwd_data_c = wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage: forwards operands, detects load-use hazards and registers ALU inputs.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alu_src_b,
  input  logic            in_uses_rs2,
  input  logic [2:0]      in_alu_control,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic            in_reg_write,
  input  logic            fwd_ex_valid,
  input  logic            fwd_ex_is_load,
  input  logic [RA_W-1:0] fwd_ex_addr,
  input  logic [XLEN-1:0] fwd_ex_data,
  input  logic            fwd_wb_valid,
  input  logic [RA_W-1:0] fwd_wb_addr,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_control,
  output logic [XLEN-1:0] out_store_data,
  output logic [RA_W-1:0] out_rd_addr,
  output logic            out_reg_write,
  output logic            hazard_stall
);

  logic [XLEN-1:0] rs1_fwd_c;
  logic [XLEN-1:0] rs2_fwd_c;
  logic            out_free_c;

  logic            out_valid_q,      out_valid_d;
  logic [XLEN-1:0] out_a_q,          out_a_d;
  logic [XLEN-1:0] out_b_q,          out_b_d;
  logic [2:0]      out_control_q,    out_control_d;
  logic [XLEN-1:0] out_store_data_q, out_store_data_d;
  logic [RA_W-1:0] out_rd_addr_q,    out_rd_addr_d;
  logic            out_reg_write_q,  out_reg_write_d;

  operand_forward_mux u_fwd_rs1 (
    .rs_addr    (in_rs1_addr),
    .rf_data    (in_rs1_data),
    .ex_valid   (fwd_ex_valid),
    .ex_is_load (fwd_ex_is_load),
    .ex_addr    (fwd_ex_addr),
    .ex_data    (fwd_ex_data),
    .wb_valid   (fwd_wb_valid),
    .wb_addr    (fwd_wb_addr),
    .wb_data    (fwd_wb_data),
    .fwd_data_c (rs1_fwd_c)
  );

  operand_forward_mux u_fwd_rs2 (
    .rs_addr    (in_rs2_addr),
    .rf_data    (in_rs2_data),
    .ex_valid   (fwd_ex_valid),
    .ex_is_load (fwd_ex_is_load),
    .ex_addr    (fwd_ex_addr),
    .ex_data    (fwd_ex_data),
    .wb_valid   (fwd_wb_valid),
    .wb_addr    (fwd_wb_addr),
    .wb_data    (fwd_wb_data),
    .fwd_data_c (rs2_fwd_c)
  );

  // Load-use hazard detection and upstream handshake.
  always_comb begin
    hazard_stall = in_valid && fwd_ex_valid && fwd_ex_is_load && (fwd_ex_addr != '0) &&
                   ((fwd_ex_addr == in_rs1_addr) ||
                    (in_uses_rs2 && (fwd_ex_addr == in_rs2_addr)));
    out_free_c   = !out_valid_q || out_ready;
    in_ready     = !hazard_stall && out_free_c;
  end

  // Next-state: flush kills, backpressure holds, stall bubbles, else capture or drain.
  always_comb begin
    out_valid_d      = out_valid_q;
    out_a_d          = out_a_q;
    out_b_d          = out_b_q;
    out_control_d    = out_control_q;
    out_store_data_d = out_store_data_q;
    out_rd_addr_d    = out_rd_addr_q;
    out_reg_write_d  = out_reg_write_q;
    if (flush) begin
      out_valid_d     = 1'b0;
      out_reg_write_d = 1'b0;
    end else if (out_free_c) begin
      if (in_valid && !hazard_stall) begin
        out_valid_d      = 1'b1;
        out_a_d          = rs1_fwd_c;
        out_b_d          = in_alu_src_b ? in_imm : rs2_fwd_c;
        out_control_d    = in_alu_control;
        out_store_data_d = rs2_fwd_c;
        out_rd_addr_d    = in_rd_addr;
        out_reg_write_d  = in_reg_write;
      end else begin
        out_valid_d     = 1'b0;
        out_reg_write_d = 1'b0;
      end
    end
  end

  // Output pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q      <= 1'b0;
      out_a_q          <= '0;
      out_b_q          <= '0;
      out_control_q    <= '0;
      out_store_data_q <= '0;
      out_rd_addr_q    <= '0;
      out_reg_write_q  <= 1'b0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_a_q          <= out_a_d;
      out_b_q          <= out_b_d;
      out_control_q    <= out_control_d;
      out_store_data_q <= out_store_data_d;
      out_rd_addr_q    <= out_rd_addr_d;
      out_reg_write_q  <= out_reg_write_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_a          = out_a_q;
  assign out_b          = out_b_q;
  assign out_control    = out_control_q;
  assign out_store_data = out_store_data_q;
  assign out_rd_addr    = out_rd_addr_q;
  assign out_reg_write  = out_reg_write_q;

endmodule
